// File: rtl/memory_pkg.sv
// Shared memory-subsystem definitions used by the D1 cache blocks.
package memory_pkg;

    // Set-index width of the D1 data cache
    localparam int DCACHE_IDX_LEN = 6;

    // Sweep sequencer states
    typedef enum logic [2:0] {
        SCAN,
        WB_REQ,
        CLEAR,
        DONE,
        IDLE
    } d1_walk_state_t;

    // Sweep flavour: invalidate-only after reset, or writeback-then-invalidate
    typedef enum logic {
        INIT,
        FLUSH
    } d1_walk_mode_t;

endpackage

// File: rtl/d1_flush_walker.sv
// D1 flush walker: steps through every cache set index and drives the
// one-hot line decoder so each line's valid/dirty status is cleared.
// Dirty lines are handed to the writeback unit first when flushing.
module d1_flush_walker
    import memory_pkg::*;
#(
    parameter int IDX_LEN = DCACHE_IDX_LEN
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_req_i,
    input  logic [(1<<IDX_LEN)-1:0]    dirty_vec_i,
    input  logic                       arr_ready_i,
    input  logic                       wb_ack_i,
    output logic [IDX_LEN-1:0]         idx_o,
    output logic                       idx_en_o,
    output logic                       wb_req_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam logic [IDX_LEN-1:0] IDX_LAST = '1;

    d1_walk_state_t     state_q, state_d;
    d1_walk_mode_t      mode_q, mode_d;
    logic [IDX_LEN-1:0] idx_q, idx_d;
    logic               pending_q, pending_d;

    // State registers; reset launches an invalidate-only sweep from line 0
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= SCAN;
            mode_q    <= INIT;
            idx_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
        end
    end

    // Next-state logic: scan, optional writeback, clear, then finish or restart
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        idx_d     = idx_q;
        pending_d = pending_q;

        if (flush_req_i && (state_q != IDLE) && (state_q != DONE)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            SCAN: begin
                if ((mode_q == FLUSH) && dirty_vec_i[idx_q]) begin
                    state_d = WB_REQ;
                end else begin
                    state_d = CLEAR;
                end
            end
            WB_REQ: begin
                if (wb_ack_i) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (arr_ready_i) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = SCAN;
                    end
                end
            end
            DONE: begin
                if (pending_q || flush_req_i) begin
                    pending_d = 1'b0;
                    mode_d    = FLUSH;
                    idx_d     = '0;
                    state_d   = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (flush_req_i) begin
                    mode_d  = FLUSH;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes decode directly from the state so reset clears them asynchronously
    assign idx_o    = idx_q;
    assign idx_en_o = (state_q == CLEAR);
    assign wb_req_o = (state_q == WB_REQ);
    assign done_o   = (state_q == DONE);
    assign busy_o   = (state_q != IDLE);

endmodule
